mem_exc_unit: RTL
=================

Name: mem_exc_unit

Overview:
- Parametrised, registered successor to the M-stage memory exception check.
- Classifies each M-stage access against a configurable address map: DM window plus NUM_DEV device windows, each with its own size and read-only word mask.
- Registers the result and holds the first exception for CP0 until it is acknowledged.
- Keeps a saturating exception counter for debug.
- Sits between M-stage ALU/byte-op decode and CP0.

Parameters:
- NUM_DEV, 3, number of device windows (1..8)
- DM_END, 32'h0000_2fff, last valid DM byte address; DM starts at 0
- DEV_BASE, {32'h7f20,32'h7f10,32'h7f00}, packed NUM_DEV*32 base byte addresses; device i occupies slice [32*i +: 32]
- DEV_WORDS, {3'd1,3'd3,3'd3}, packed NUM_DEV*3 window sizes in words (1..7)
- DEV_RO_MASK, {8'h00,8'h04,8'h04}, packed NUM_DEV*8; bit k set = word k of device i is read-only
- CNT_W, 16, exception counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  M-stage instruction valid this cycle
- pc  in  32  M-stage PC
- pc_adel  in  1  instruction fetch address error carried down the pipe
- addr  in  32  data address (ALU result)
- byte_op  in  3  0 none, 1 Sw, 2 Sb, 3 Sh, 4 Lw, 5 Lb, 6 Lh
- ov_in  in  1  ALU overflow
- flush  in  1  discard the in-flight registered result (eret / exception entry)
- exc_ack  in  1  CP0 has taken the held exception
- exc_valid  out  1  exception held and presented
- exc_code  out  5  4 AdEL, 5 AdES, 12 Ov
- bad_vaddr  out  32  faulting address
- exc_count  out  CNT_W  saturating count of detected exceptions

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs 0; state IDLE; stage register invalid.
- Detect (combinational, from the inputs, only when req_valid). First match wins:
  1. pc_adel: code 4, vaddr = pc. Applies for any byte_op.
  2. ov_in & byte_op==0: code 12, vaddr = pc.
  3. ov_in & byte_op!=0 (address overflow): AdEL for load, AdES for store, vaddr = addr.
  4. Misalignment: Lw/Sw with addr[1:0]!=0, or Lh/Sh with addr[0]!=0. Load→4, store→5.
  5. addr outside DM and outside every device window: load→4, store→5. Device window i is [base_i, base_i + 4*words_i - 1].
  6. Any device hit with byte_op other than Lw/Sw: load→4, store→5.
  7. Store to a device word whose DEV_RO_MASK bit is set: code 5. Word index = (addr - base)>>2.
  - byte_op 7 is treated as none.
- Stage: detect result registered on the posedge (1-cycle latency); flush clears the registered result.
- FSM, two states:
  - IDLE: a registered, unflushed hit loads exc_code/bad_vaddr, raises exc_valid, and moves to HOLD.
  - HOLD: outputs frozen. Later hits are not captured but still counted.
    - exc_ack alone: drop exc_valid, go to IDLE.
    - exc_ack together with a new registered hit: load the new hit and stay in HOLD (exc_valid stays 1).
- exc_count:
  - +1 per registered, unflushed hit; saturates at all-ones.
  - Not cleared by flush or ack; only reset clears it.
- exc_ack in IDLE is ignored.
- Reset mid-HOLD: returns immediately to IDLE with outputs 0.
- All address compares are 32-bit unsigned; base + size is computed in 33 bits so a window at the top of the space does not wrap.

Decomposition:
- Shared package/header holds:
  - byte_op encodings: BOP_NONE, BOP_SW, BOP_SB, BOP_SH, BOP_LW, BOP_LB, BOP_LH
  - exc codes: EXC_ADEL=4, EXC_ADES=5, EXC_OV=12
  - default DM/device map constants
- One sub-module, mem_window_match: per-window hit, word index and read-only flag. Instantiated NUM_DEV times with a generate loop; the top level priority-encodes the results.

Test Plan:
- Lw addr 32'h7f04, no other faults → no exception; exc_valid stays 0; exc_count 0.
- Sw addr 32'h7f08 (timer0 word 2, RO) → exc_valid 1 the cycle after; exc_code 5; bad_vaddr 32'h7f08.
- Lh addr 32'h0001 → code 4, bad_vaddr 1. Next cycle, while held, Lw addr 32'h3000 → exc_code/bad_vaddr unchanged; exc_count 2. Then exc_ack → exc_valid 0.
- Add with ov_in=1, byte_op 0, pc 32'h3010 → code 12, bad_vaddr 32'h3010. Same hit with flush asserted in the capture cycle → nothing held; counter unchanged.
- Held exception plus exc_ack in the same cycle as a new hit Sb 32'h7f20 → exc_valid stays 1; code 5; bad_vaddr 32'h7f20.
- Set CNT_W=2, inject 5 hits → exc_count saturates at 3. Assert reset while HOLD → all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/mem_exc_unit_pkg.sv
// Shared encodings, default address map and small helpers for the M-stage
// memory exception unit.
package mem_exc_unit_pkg;

  localparam logic [2:0] BOP_NONE = 3'd0;
  localparam logic [2:0] BOP_SW   = 3'd1;
  localparam logic [2:0] BOP_SB   = 3'd2;
  localparam logic [2:0] BOP_SH   = 3'd3;
  localparam logic [2:0] BOP_LW   = 3'd4;
  localparam logic [2:0] BOP_LB   = 3'd5;
  localparam logic [2:0] BOP_LH   = 3'd6;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic        hit;
    logic [4:0]  code;
    logic [31:0] vaddr;
  } exc_rec_t;

  localparam int unsigned  DEF_NUM_DEV     = 3;
  localparam logic [31:0]  DEF_DM_END      = 32'h0000_2fff;
  localparam logic [95:0]  DEF_DEV_BASE    = {32'h0000_7f20, 32'h0000_7f10, 32'h0000_7f00};
  localparam logic [8:0]   DEF_DEV_WORDS   = {3'd1, 3'd3, 3'd3};
  localparam logic [23:0]  DEF_DEV_RO_MASK = {8'h00, 8'h04, 8'h04};

  function automatic logic is_load(input logic [2:0] op);
    return (op == BOP_LW) || (op == BOP_LB) || (op == BOP_LH);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == BOP_SW) || (op == BOP_SB) || (op == BOP_SH);
  endfunction

  function automatic exc_rec_t mk_exc(input logic [4:0] code, input logic [31:0] vaddr);
    exc_rec_t rec;
    rec.hit   = 1'b1;
    rec.code  = code;
    rec.vaddr = vaddr;
    return rec;
  endfunction

endpackage

// File: rtl/mem_exc_unit_if.sv
// M-stage request / CP0 exception bus of the memory exception unit.
interface mem_exc_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req_valid;
  logic [31:0]      pc;
  logic             pc_adel;
  logic [31:0]      addr;
  logic [2:0]       byte_op;
  logic             ov_in;
  logic             flush;
  logic             exc_ack;
  logic             exc_valid;
  logic [4:0]       exc_code;
  logic [31:0]      bad_vaddr;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output req_valid, pc, pc_adel, addr, byte_op, ov_in, flush, exc_ack,
    input  exc_valid, exc_code, bad_vaddr, exc_count
  );

  modport slave (
    input  req_valid, pc, pc_adel, addr, byte_op, ov_in, flush, exc_ack,
    output exc_valid, exc_code, bad_vaddr, exc_count
  );
endinterface

// File: rtl/mem_window_match.sv
// One device window: hit test and read-only flag of the addressed word.
module mem_window_match #(
  parameter logic [31:0] BASE    = 32'h0000_7f00,
  parameter logic [2:0]  WORDS   = 3'd1,
  parameter logic [7:0]  RO_MASK = 8'h00
) (
  input  logic [31:0] addr,
  output logic        hit,
  output logic        ro
);
  logic [32:0] limit_s;
  logic [2:0]  word_idx_s;

  // Limit in 33 bits so a window ending at 32'hffff_ffff does not wrap.
  assign limit_s    = {1'b0, BASE} + {28'd0, WORDS, 2'b00};
  assign word_idx_s = 3'((addr - BASE) >> 2);
  assign hit        = (addr >= BASE) && ({1'b0, addr} < limit_s);
  assign ro         = hit && RO_MASK[word_idx_s];

endmodule

// File: rtl/mem_exc_unit.sv
// M-stage memory exception check: classifies the access, registers the
// result and holds the first exception for CP0 until acknowledged.
module mem_exc_unit
  import mem_exc_unit_pkg::*;
#(
  parameter int unsigned            NUM_DEV     = DEF_NUM_DEV,
  parameter logic [31:0]            DM_END      = DEF_DM_END,
  parameter logic [NUM_DEV*32-1:0]  DEV_BASE    = DEF_DEV_BASE,
  parameter logic [NUM_DEV*3-1:0]   DEV_WORDS   = DEF_DEV_WORDS,
  parameter logic [NUM_DEV*8-1:0]   DEV_RO_MASK = DEF_DEV_RO_MASK,
  parameter int unsigned            CNT_W       = 16
) (
  input  logic     clk,
  input  logic     reset,
  mem_exc_if.slave bus
);
  logic [NUM_DEV-1:0] win_hit_s;
  logic [NUM_DEV-1:0] win_ro_s;
  logic               dev_hit_s;
  logic               sel_ro_s;
  logic               is_mem_s;
  logic               word_op_s;
  logic               in_dm_s;
  logic               misal_s;
  logic               hit_s;
  exc_code_e          acc_code_s;
  exc_rec_t           det_s;

  state_e             state_r;
  logic               exc_valid_r;
  logic [4:0]         exc_code_r;
  logic [31:0]        bad_vaddr_r;
  logic [CNT_W-1:0]   cnt_r;

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_win
    mem_window_match #(
      .BASE    (DEV_BASE[32*i +: 32]),
      .WORDS   (DEV_WORDS[3*i +: 3]),
      .RO_MASK (DEV_RO_MASK[8*i +: 8])
    ) u_win (
      .addr (bus.addr),
      .hit  (win_hit_s[i]),
      .ro   (win_ro_s[i])
    );
  end

  assign dev_hit_s  = |win_hit_s;
  assign is_mem_s   = is_load(bus.byte_op) || is_store(bus.byte_op);
  assign word_op_s  = (bus.byte_op == BOP_LW) || (bus.byte_op == BOP_SW);
  assign in_dm_s    = (bus.addr <= DM_END);
  assign acc_code_s = is_load(bus.byte_op) ? EXC_ADEL : EXC_ADES;
  assign hit_s      = det_s.hit && !bus.flush;

  // Lowest-numbered matching window supplies the read-only flag.
  always_comb begin
    sel_ro_s = 1'b0;
    for (int i = int'(NUM_DEV) - 1; i >= 0; i--) begin
      if (win_hit_s[i]) begin
        sel_ro_s = win_ro_s[i];
      end else begin
        sel_ro_s = sel_ro_s;
      end
    end
  end

  // Alignment check by access width.
  always_comb begin
    misal_s = 1'b0;
    case (bus.byte_op)
      BOP_LW, BOP_SW: misal_s = (bus.addr[1:0] != 2'b00);
      BOP_LH, BOP_SH: misal_s = bus.addr[0];
      default:        misal_s = 1'b0;
    endcase
  end

  // Priority classification; earlier rules shadow later ones.
  always_comb begin
    det_s = '0;
    if (!bus.req_valid) begin
      det_s = '0;
    end else if (bus.pc_adel) begin
      det_s = mk_exc(EXC_ADEL, bus.pc);
    end else if (bus.ov_in && !is_mem_s) begin
      det_s = mk_exc(EXC_OV, bus.pc);
    end else if (bus.ov_in) begin
      det_s = mk_exc(acc_code_s, bus.addr);
    end else if (!is_mem_s) begin
      det_s = '0;
    end else if (misal_s) begin
      det_s = mk_exc(acc_code_s, bus.addr);
    end else if (!in_dm_s && !dev_hit_s) begin
      det_s = mk_exc(acc_code_s, bus.addr);
    end else if (dev_hit_s && !word_op_s) begin
      det_s = mk_exc(acc_code_s, bus.addr);
    end else if (dev_hit_s && is_store(bus.byte_op) && sel_ro_s) begin
      det_s = mk_exc(EXC_ADES, bus.addr);
    end else begin
      det_s = '0;
    end
  end

  // Hold FSM: first exception is frozen until CP0 acknowledges it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      exc_valid_r <= 1'b0;
      exc_code_r  <= 5'd0;
      bad_vaddr_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            exc_valid_r <= 1'b1;
            exc_code_r  <= det_s.code;
            bad_vaddr_r <= det_s.vaddr;
            state_r     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.exc_ack && hit_s) begin
            exc_code_r  <= det_s.code;
            bad_vaddr_r <= det_s.vaddr;
          end else if (bus.exc_ack) begin
            exc_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          exc_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating debug count of every registered, unflushed hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (hit_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.exc_valid = exc_valid_r;
  assign bus.exc_code  = exc_code_r;
  assign bus.bad_vaddr = bad_vaddr_r;
  assign bus.exc_count = cnt_r;

endmodule
